// File: rtl/tick_timer_pkg.sv
// ============================================================================
// Package : tick_timer_pkg
// Brief   : Shared state encoding and constants for the tick timer controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package tick_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Smallest legal divide ratio; a requested ratio of 0 is raised to this.
  localparam int DIV_MIN = 1;

endpackage

`default_nettype wire

// File: rtl/tick_timer_ctrl_if.sv
// ============================================================================
// Interface : tick_timer_ctrl_if
// Brief     : Config handshake, countdown control and tick/status outputs.
// Rev       : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tick_timer_ctrl_if #(
  parameter int CNT_W = 16,
  parameter int TMR_W = 16
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_div;
  logic             start;
  logic             stop;
  logic             pause;
  logic [TMR_W-1:0] load_cnt;
  logic             tick;
  logic             clk_div;
  logic             busy;
  logic             done;
  logic [TMR_W-1:0] remaining;

  modport master (
    output cfg_valid, cfg_div, start, stop, pause, load_cnt,
    input  cfg_ready, tick, clk_div, busy, done, remaining
  );

  modport slave (
    input  cfg_valid, cfg_div, start, stop, pause, load_cnt,
    output cfg_ready, tick, clk_div, busy, done, remaining
  );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module : tick_prescaler
// Brief  : Free-running prescaler with glitch-free divide-ratio reload.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
  import tick_timer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50000
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             cfg_valid,
  output logic                  cfg_ready,
  input  wire logic [CNT_W-1:0] cfg_div,
  output logic                  tick,
  output logic                  clk_div
);

  localparam logic [CNT_W-1:0] C_DIV_MIN = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] C_RST_DIV =
    (DEFAULT_DIV < DIV_MIN) ? CNT_W'(DIV_MIN) : CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] pre_cnt_q,  pre_cnt_d;
  logic [CNT_W-1:0] div_q,      div_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pending_q,  pending_d;
  logic             clk_div_q,  clk_div_d;
  logic             tick_w;
  logic             accept_w;

  assign tick_w    = (pre_cnt_q == div_q - CNT_W'(1));
  assign accept_w  = cfg_valid && !pending_q;
  assign cfg_ready = !pending_q;
  assign tick      = tick_w;
  assign clk_div   = clk_div_q;

  always_comb begin
    pre_cnt_d  = tick_w ? '0 : pre_cnt_q + CNT_W'(1);
    clk_div_d  = clk_div_q ^ tick_w;
    div_d      = div_q;
    div_pend_d = div_pend_q;
    pending_d  = pending_q;
    // A held ratio only lands on a period boundary, so the next period is
    // the first one at the new length. Accept and apply are exclusive
    // because accept requires no ratio already pending.
    if (pending_q && tick_w) begin
      div_d     = div_pend_q;
      pending_d = 1'b0;
    end else if (accept_w) begin
      div_pend_d = (cfg_div < C_DIV_MIN) ? C_DIV_MIN : cfg_div;
      pending_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q  <= '0;
      div_q      <= C_RST_DIV;
      div_pend_q <= C_RST_DIV;
      pending_q  <= 1'b0;
      clk_div_q  <= 1'b0;
    end else begin
      pre_cnt_q  <= pre_cnt_d;
      div_q      <= div_d;
      div_pend_q <= div_pend_d;
      pending_q  <= pending_d;
      clk_div_q  <= clk_div_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tick_timer_ctrl.sv
// ============================================================================
// Module : tick_timer_ctrl
// Brief  : Countdown sequencer (start/stop/pause/done) over a tick prescaler.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_timer_ctrl
  import tick_timer_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50000,
  parameter int TMR_W       = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  tick_timer_ctrl_if.slave bus
);

  state_e           state_q,     state_d;
  logic [TMR_W-1:0] remaining_q, remaining_d;
  logic             done_q,      done_d;
  logic             busy_q,      busy_d;
  logic             tick_w;
  logic             clk_div_w;
  logic             cfg_ready_w;

  tick_prescaler #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) u_prescaler (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (bus.cfg_valid),
    .cfg_ready (cfg_ready_w),
    .cfg_div   (bus.cfg_div),
    .tick      (tick_w),
    .clk_div   (clk_div_w)
  );

  assign bus.cfg_ready = cfg_ready_w;
  assign bus.tick      = tick_w;
  assign bus.clk_div   = clk_div_w;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.remaining = remaining_q;

  // Per-cycle priority is stop > start > pause > tick.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          if (bus.load_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            remaining_d = bus.load_cnt;
            state_d     = RUN;
          end
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (bus.pause) begin
          state_d = PAUSE;
        end else if (tick_w) begin
          if (remaining_q <= TMR_W'(1)) begin
            remaining_d = '0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            remaining_d = remaining_q - TMR_W'(1);
          end
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d     = IDLE;
          remaining_d = '0;
        end else if (!bus.pause) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tick_timer_ctrl.sv
// ============================================================================
// Module : tb_tick_timer_ctrl
// Brief  : Self-checking bench: vector table, corner sequences, random run.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tick_timer_ctrl;

  localparam int CNT_W       = 8;
  localparam int TMR_W       = 8;
  localparam int DEFAULT_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tick_timer_ctrl_if #(.CNT_W(CNT_W), .TMR_W(TMR_W)) bus ();

  tick_timer_ctrl #(
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV),
    .TMR_W       (TMR_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (absolute-time view) ----------------
  int  m_cyc, m_next, m_div, m_pdiv, m_ntick, m_left;
  bit  m_pend, m_active, m_paused, m_done, model_valid;

  task automatic model_reset();
    m_cyc = 0; m_next = DEFAULT_DIV - 1; m_div = DEFAULT_DIV; m_pdiv = 0;
    m_ntick = 0; m_left = 0; m_pend = 0; m_active = 0; m_paused = 0; m_done = 0;
  endtask

  task automatic model_step();
    bit t, pend_old, nd;
    t = (m_cyc == m_next);
    pend_old = m_pend;
    nd = 0;
    if (t) begin
      m_ntick++;
      if (pend_old) begin m_div = m_pdiv; m_pend = 0; end
      m_next = m_cyc + m_div;
    end
    if (bus.cfg_valid && !pend_old) begin
      m_pdiv = (bus.cfg_div == 0) ? 1 : int'(bus.cfg_div);
      m_pend = 1;
    end
    if (bus.stop) begin
      m_active = 0; m_paused = 0; m_left = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        if (bus.load_cnt == 0) nd = 1;
        else begin m_active = 1; m_paused = 0; m_left = int'(bus.load_cnt); end
      end
    end else if (m_paused) begin
      if (!bus.pause) m_paused = 0;
    end else if (bus.pause) begin
      m_paused = 1;
    end else if (t) begin
      m_left--;
      if (m_left == 0) begin m_active = 0; nd = 1; end
    end
    m_done = nd;
    m_cyc++;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".tick"},      32'(bus.tick),      32'(m_cyc == m_next));
    chk({tag, ".clk_div"},   32'(bus.clk_div),   32'(m_ntick % 2));
    chk({tag, ".cfg_ready"}, 32'(bus.cfg_ready), 32'(!m_pend));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_active));
    chk({tag, ".done"},      32'(bus.done),      32'(m_done));
    chk({tag, ".remaining"}, 32'(bus.remaining), 32'(m_left));
  endtask

  task automatic cycle(input string tag);
    if (model_valid) check_all(tag);
    if (rst) begin model_reset(); model_valid = 1; end
    else model_step();
    @(posedge clk); #1;
  endtask

  task automatic set_in(input bit cv, input logic [7:0] cd, input bit st,
                        input bit sp, input bit pa, input logic [7:0] ld);
    bus.cfg_valid = cv; bus.cfg_div = cd; bus.start = st;
    bus.stop = sp; bus.pause = pa; bus.load_cnt = ld;
  endtask

  task automatic do_reset();
    model_valid = 0;
    rst = 1; set_in(0, 0, 0, 0, 0, 0);
    cycle("rst");
    rst = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit r; bit cv; logic [7:0] cd; bit st; logic [7:0] ld;
    bit t; bit ck; bit rdy; bit b; bit d; logic [7:0] rem;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit r, input bit cv, input logic [7:0] cd,
                              input bit st, input logic [7:0] ld, input bit t,
                              input bit ck, input bit rdy, input bit b,
                              input bit d, input logic [7:0] rem);
    vec_t v;
    v.r = r; v.cv = cv; v.cd = cd; v.st = st; v.ld = ld;
    v.t = t; v.ck = ck; v.rdy = rdy; v.b = b; v.d = d; v.rem = rem;
    vecs.push_back(v);
  endfunction

  int  done_at, done_cnt;
  bit  pa;

  initial begin
    set_in(0, 0, 0, 0, 0, 0);
    model_valid = 0;

    // countdown of 3 from cycle 0:   r cv cd st ld  t ck rdy b d rem
    add(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 3,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 3);
    add(0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  0, 1, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  1, 1, 1, 1, 0, 2);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    // ratio 2 offered at cycle 5
    add(1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    add(0, 1, 2, 0, 0,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0,  0, 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].r;
      set_in(vecs[i].cv, vecs[i].cd, vecs[i].st, 0, 0, vecs[i].ld);
      if (!vecs[i].r) begin
        chk($sformatf("vec%0d.tick", i),      32'(bus.tick),      32'(vecs[i].t));
        chk($sformatf("vec%0d.clk_div", i),   32'(bus.clk_div),   32'(vecs[i].ck));
        chk($sformatf("vec%0d.cfg_ready", i), 32'(bus.cfg_ready), 32'(vecs[i].rdy));
        chk($sformatf("vec%0d.busy", i),      32'(bus.busy),      32'(vecs[i].b));
        chk($sformatf("vec%0d.done", i),      32'(bus.done),      32'(vecs[i].d));
        chk($sformatf("vec%0d.remaining", i), 32'(bus.remaining), 32'(vecs[i].rem));
      end
      @(posedge clk); #1;
    end
    rst = 0;

    // pause across a tick delays completion by one full period
    do_reset();
    done_at = -1;
    for (int c = 0; c < 22; c++) begin
      set_in(0, 0, c == 0, 0, (c >= 5 && c <= 9), 3);
      if (c == 8) chk("pause_rem_held", 32'(bus.remaining), 32'd2);
      if (bus.done) done_at = c;
      cycle("pause");
    end
    chk("pause_done_cycle", 32'(done_at), 32'd16);

    // stop coinciding with the final tick suppresses done
    do_reset();
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      set_in(0, 0, c == 0, c == 3, 0, 1);
      if (c == 3) chk("stop_tick_present", 32'(bus.tick), 32'd1);
      if (c == 4) begin
        chk("stop_busy", 32'(bus.busy), 32'd0);
        chk("stop_rem", 32'(bus.remaining), 32'd0);
      end
      if (bus.done) done_cnt++;
      cycle("stop");
    end
    chk("stop_no_done", 32'(done_cnt), 32'd0);

    // zero-length countdown
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_in(0, 0, c == 0, 0, 0, 0);
      if (c == 1) begin
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_busy", 32'(bus.busy), 32'd0);
      end
      if (c == 2) chk("zero_done_pulse", 32'(bus.done), 32'd0);
      cycle("zero");
    end

    // ratio 0 behaves as 1: tick held high once applied
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_in(c == 0, 0, 0, 0, 0, 0);
      if (c == 2) chk("div0_ready_low", 32'(bus.cfg_ready), 32'd0);
      if (c >= 4) chk($sformatf("div0_tick_c%0d", c), 32'(bus.tick), 32'd1);
      cycle("div0");
    end

    // reset in the middle of a countdown aborts without done
    do_reset();
    for (int c = 0; c < 6; c++) begin
      set_in(0, 0, c == 0, 0, 0, 5);
      cycle("mid");
    end
    chk("mid_busy_before", 32'(bus.busy), 32'd1);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 0, 0, 0);
      chk("mid_done", 32'(bus.done), 32'd0);
      cycle("mid_after");
    end

    // randomized run against the model
    do_reset();
    pa = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(7) == 0) pa = !pa;
      rst = ($urandom_range(399) == 0);
      set_in($urandom_range(7) == 0, 8'($urandom_range(5)),
             $urandom_range(9) == 0, $urandom_range(39) == 0, pa,
             8'($urandom_range(6)));
      cycle("rand");
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
